mux32_arbiter: RTL and testbench



---
 rtl/mux_arb_pkg.sv | 39 +++
 rtl/rr_pick32.sv | 31 +++
 rtl/mux32_arbiter.sv | 138 +++++++++++++
 tb/tb_mux32_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared sizes, FSM state and output bundle for the mux32
// round-robin arbiter.
//   NUM_REQ : number of requesters / mux inputs (32)
//   SEL_W   : width of the mux select (5)
//   CNT_W   : width of the grant wait counter (8)
package mux_arb_pkg;

  localparam int NUM_REQ = 32;
  localparam int SEL_W   = 5;
  localparam int CNT_W   = 8;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  // Registered arbiter response; the three fields always move together so
  // valid, select and grant can never disagree.
  typedef struct packed {
    logic               vld;
    logic [SEL_W-1:0]   sel;
    logic [NUM_REQ-1:0] gnt;
  } arb_out_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  function automatic arb_out_t mk_grant(input logic [SEL_W-1:0] i);
    mk_grant.vld = 1'b1;
    mk_grant.sel = i;
    mk_grant.gnt = onehot(i);
  endfunction

  function automatic arb_out_t mk_idle(input logic [SEL_W-1:0] i);
    mk_idle.vld = 1'b0;
    mk_idle.sel = i;
    mk_idle.gnt = '0;
  endfunction

endpackage

// File: rtl/rr_pick32.sv
// rr_pick32: combinational rotate-priority encoder.
//   req [31:0] : request vector
//   ptr [4:0]  : highest-priority index; search runs ptr, ptr+1, ... wrapping 31->0
//   any        : at least one request set
//   idx [4:0]  : winning index (0 when any=0)
module rr_pick32
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [NUM_REQ-1:0] rot;
  logic [SEL_W-1:0]   off;

  // Rotate so bit ptr lands at position 0; the lowest set bit of rot is then
  // the winner's distance from ptr.
  assign rot = NUM_REQ'({req, req} >> ptr);

  always_comb begin
    off = '0;
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (rot[i]) off = SEL_W'(i);
  end

  assign any = |req;
  assign idx = off + ptr;  // 5-bit add wraps mod 32

endmodule

// File: rtl/mux32_arbiter.sv
// mux32_arbiter: round-robin arbiter/sequencer driving the select of a
// shared 32:1 mux. Holds a grant until ready, aborts on request withdrawal
// or after TIMEOUT cycles without ready.
//   clk, rst    : clock, asynchronous active-high reset
//   req [31:0]  : request vector
//   ready       : consumer accepts the current selection this cycle
//   select[4:0] : granted index (mux select)
//   grant[31:0] : one-hot grant, zero when idle
//   valid       : live grant on select/grant
//   timeout_err : one-cycle pulse when a grant times out
// Parameter TIMEOUT (0..255, 0 = no timeout).
// Build option MUX_ARB_PARK_EN: when defined, select parks on the last
// granted/aborted index while idle instead of returning to 0.
module mux32_arbiter
  import mux_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               ready,
  output logic [SEL_W-1:0]   select,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid,
  output logic               timeout_err
);

`ifdef MUX_ARB_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif

  localparam bit             TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t             state_q, state_d;
  arb_out_t           out_q, out_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [SEL_W-1:0]   nxt_ptr, idle_sel;
  logic               any_i, any_n;
  logic [SEL_W-1:0]   idx_i, idx_n;

  // Pointer after the current grant completes; the old winner becomes
  // lowest priority.
  assign nxt_ptr  = out_q.sel + SEL_W'(1);
  assign idle_sel = PARK ? out_q.sel : '0;

  // Fresh pick from IDLE uses the stored pointer.
  rr_pick32 u_pick_idle (
    .req (req),
    .ptr (ptr_q),
    .any (any_i),
    .idx (idx_i)
  );

  // Re-pick on ready uses the already-advanced pointer so back-to-back
  // grants need no bubble cycle.
  rr_pick32 u_pick_next (
    .req (req),
    .ptr (nxt_ptr),
    .any (any_n),
    .idx (idx_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_i) begin
          state_d = GRANT;
          out_d   = mk_grant(idx_i);
          cnt_d   = '0;
        end
      end
      GRANT: begin
        // Order matters: ready beats withdrawal, withdrawal beats timeout.
        if (ready) begin
          ptr_d = nxt_ptr;
          cnt_d = '0;
          if (any_n) begin
            out_d = mk_grant(idx_n);
          end else begin
            state_d = IDLE;
            out_d   = mk_idle(idle_sel);
          end
        end else if (!req[out_q.sel]) begin
          state_d = IDLE;
          out_d   = mk_idle(idle_sel);
          cnt_d   = '0;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          // Skip the stuck requester so a dead consumer cannot starve others.
          err_d   = 1'b1;
          ptr_d   = nxt_ptr;
          state_d = IDLE;
          out_d   = mk_idle(idle_sel);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = '0;
      end
    endcase
  end

  assign select      = out_q.sel;
  assign grant       = out_q.gnt;
  assign valid       = out_q.vld;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_mux32_arbiter.sv
module tb_mux32_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req;
  logic        ready;
  logic [4:0]  select;
  logic [31:0] grant;
  logic        valid;
  logic        timeout_err;

  int pass_cnt = 0;
  int total    = 0;

`ifdef MUX_ARB_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif

  mux32_arbiter #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .ready       (ready),
    .select      (select),
    .grant       (grant),
    .valid       (valid),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Advance one clock; sample point and drive point is 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; ready = 1'b0;
    #12;
    total++;
    if ({valid, grant, select, timeout_err} !== 39'd0)
      $display("FAIL reset: valid=%b grant=%h select=%0d err=%b, want all 0", valid, grant, select, timeout_err);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    total++;
    if (valid !== 1'b0) $display("FAIL reset_idle: valid=%b want 0", valid); else pass_cnt++;
  endtask

  // ptr 0 -> 2 at exit
  task automatic test_single();
    req = 32'h1; ready = 1'b0;
    tick();
    total++;
    if (!(valid === 1'b1 && select === 5'd0 && grant === 32'h1))
      $display("FAIL single_grant: valid=%b select=%0d grant=%h want 1/0/00000001", valid, select, grant);
    else pass_cnt++;
    req = 32'h0; ready = 1'b1;
    tick();
    total++;
    if (!(valid === 1'b0 && grant === 32'h0 && select === 5'd0))
      $display("FAIL single_idle: valid=%b grant=%h select=%0d want 0/0/0", valid, grant, select);
    else pass_cnt++;
    // ptr should now be 1: with req 0 and 1 pending, 1 wins
    req = 32'h3; ready = 1'b0;
    tick();
    total++;
    if (select !== 5'd1) $display("FAIL single_ptr1: select=%0d want 1", select); else pass_cnt++;
    req = 32'h0; ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp;
    rst = 1'b1; #2; rst = 1'b0;
    req = 32'hFFFF_FFFF; ready = 1'b1;
    for (int i = 0; i < 34; i++) begin
      tick();
      exp = 5'(i % 32);
      total++;
      if (!(valid === 1'b1 && select === exp && grant === (32'h1 << exp)))
        $display("FAIL b2b[%0d]: valid=%b select=%0d grant=%h want 1/%0d/%h", i, valid, select, grant, exp, 32'h1 << exp);
      else pass_cnt++;
    end
    req = 32'h0;
    tick();  // completes grant 1 -> ptr 2, idle
    total++;
    if (valid !== 1'b0) $display("FAIL b2b_end: valid=%b want 0", valid); else pass_cnt++;
  endtask

  // ptr 2 -> 0
  task automatic test_wrap();
    req = 32'h8000_0000; ready = 1'b0;
    tick();
    total++;
    if (select !== 5'd31) $display("FAIL wrap_first: select=%0d want 31", select); else pass_cnt++;
    req = 32'h8000_0002; ready = 1'b1;
    tick();
    total++;
    if (select !== 5'd1) $display("FAIL wrap_next: select=%0d want 1", select); else pass_cnt++;
    tick();
    total++;
    if (select !== 5'd31) $display("FAIL wrap_back: select=%0d want 31", select); else pass_cnt++;
    req = 32'h0;
    tick();
  endtask

  // ptr 0 -> 6
  task automatic test_timeout();
    req = 32'h10; ready = 1'b0;
    tick();
    total++;
    if (!(valid === 1'b1 && select === 5'd4)) $display("FAIL to_grant: valid=%b select=%0d want 1/4", valid, select); else pass_cnt++;
    for (int i = 1; i < 16; i++) begin
      tick();
      total++;
      if (!(valid === 1'b1 && timeout_err === 1'b0 && select === 5'd4))
        $display("FAIL to_hold[%0d]: valid=%b err=%b select=%0d want 1/0/4", i, valid, timeout_err, select);
      else pass_cnt++;
    end
    req = 32'h30;
    tick();
    total++;
    if (!(valid === 1'b0 && timeout_err === 1'b1 && grant === 32'h0))
      $display("FAIL to_abort: valid=%b err=%b grant=%h want 0/1/0", valid, timeout_err, grant);
    else pass_cnt++;
    total++;
    if (select !== (PARK ? 5'd4 : 5'd0)) $display("FAIL to_idle_sel: select=%0d want %0d", select, PARK ? 4 : 0); else pass_cnt++;
    tick();
    total++;
    if (!(valid === 1'b1 && select === 5'd5 && timeout_err === 1'b0))
      $display("FAIL to_next: valid=%b select=%0d err=%b want 1/5/0", valid, select, timeout_err);
    else pass_cnt++;
    req = 32'h0; ready = 1'b1;
    tick();
  endtask

  // ptr 6 -> 5
  task automatic test_withdraw();
    req = 32'h8; ready = 1'b0;
    tick();
    total++;
    if (select !== 5'd3) $display("FAIL wd_grant: select=%0d want 3", select); else pass_cnt++;
    req = 32'h0;
    tick();
    total++;
    if (!(valid === 1'b0 && timeout_err === 1'b0 && select === (PARK ? 5'd3 : 5'd0)))
      $display("FAIL wd_abort: valid=%b err=%b select=%0d want 0/0/%0d", valid, timeout_err, select, PARK ? 3 : 0);
    else pass_cnt++;
    // ptr still 6: bits 4,7 pending -> 7 (4 if ptr had moved to 4)
    req = 32'h90;
    tick();
    total++;
    if (select !== 5'd7) $display("FAIL wd_ptr_kept: select=%0d want 7", select); else pass_cnt++;
    req = 32'h0; ready = 1'b1;
    tick();  // ptr 8
    req = 32'h8; ready = 1'b0;
    tick();
    req = 32'h0; ready = 1'b1;  // withdrawal together with ready: transfer counts
    tick();
    total++;
    if (!(valid === 1'b0 && timeout_err === 1'b0)) $display("FAIL wd_ready: valid=%b err=%b want 0/0", valid, timeout_err); else pass_cnt++;
    // ptr 4: bits 3,4 pending -> 4 (3 if ptr stayed 8)
    req = 32'h18; ready = 1'b0;
    tick();
    total++;
    if (select !== 5'd4) $display("FAIL wd_ptr4: select=%0d want 4", select); else pass_cnt++;
    req = 32'h0; ready = 1'b1;
    tick();
  endtask

  // ptr 5 -> 8
  task automatic test_async_reset_park();
    req = 32'h80; ready = 1'b0;
    tick();
    total++;
    if (select !== 5'd7) $display("FAIL ar_grant: select=%0d want 7", select); else pass_cnt++;
    #2; rst = 1'b1;
    #1;
    total++;
    if (!(valid === 1'b0 && grant === 32'h0 && select === 5'd0))
      $display("FAIL ar_async: valid=%b grant=%h select=%0d want 0/0/0", valid, grant, select);
    else pass_cnt++;
    req = 32'h0;
    #1; rst = 1'b0;
    req = 32'h80;
    tick();
    ready = 1'b1; req = 32'h0;
    tick();
    total++;
    if (!(valid === 1'b0 && select === (PARK ? 5'd7 : 5'd0)))
      $display("FAIL park_sel: valid=%b select=%0d want 0/%0d", valid, select, PARK ? 7 : 0);
    else pass_cnt++;
  endtask

  // ready arriving on the timeout cycle wins; no error pulse
  task automatic test_ready_on_timeout();
    req = 32'h100; ready = 1'b0;
    tick();
    for (int i = 1; i < 16; i++) tick();
    ready = 1'b1;
    tick();
    total++;
    if (!(valid === 1'b1 && timeout_err === 1'b0 && select === 5'd8))
      $display("FAIL rdy_to: valid=%b err=%b select=%0d want 1/0/8", valid, timeout_err, select);
    else pass_cnt++;
    req = 32'h0;
    tick();
    total++;
    if (!(valid === 1'b0 && timeout_err === 1'b0)) $display("FAIL rdy_to_end: valid=%b err=%b want 0/0", valid, timeout_err); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_timeout();
    test_withdraw();
    test_async_reset_park();
    test_ready_on_timeout();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
